c_split2_32b: RTL and testbench



---
 rtl/c_hs_pkg.sv | 21 ++
 rtl/c_sync_fifo.sv | 66 ++++++
 rtl/c_split2_32b.sv | 132 +++++++++++++
 tb/tb_c_split2_32b.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c_hs_pkg
// Brief    : Shared types for the drive/free handshake splitter: issue FSM
//            state encoding and default half-word width.
// Revision : 1.0  initial release
// ============================================================================
package c_hs_pkg;

  localparam int HALF_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BOTH = 3'd1,
    ST_WAIT0     = 3'd2,
    ST_WAIT1     = 3'd3,
    ST_POP       = 3'd4
  } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/c_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : c_sync_fifo
// Brief    : Single-clock FIFO with occupancy count; head word is always
//            visible on rdata. DEPTH must be a power of two.
// Revision : 1.0  initial release
// ============================================================================
module c_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/c_split2_32b.sv
`default_nettype none
// ============================================================================
// Module   : c_split2_32b
// Brief    : Buffers 64-bit words and issues upper/lower halves on two
//            branches; a word retires once both branches have freed it.
// Revision : 1.0  initial release
// ============================================================================
module c_split2_32b
  import c_hs_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_drive,
  input  logic [2*HALF_W-1:0] i_data_64,
  output logic                o_free,
  output logic                o_drive0,
  output logic                o_drive1,
  output logic [HALF_W-1:0]   o_data0_32,
  output logic [HALF_W-1:0]   o_data1_32,
  input  logic                i_freeNext0,
  input  logic                i_freeNext1,
  output logic                o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e        state_q, state_d;
  logic                drive_q, drive_d;
  logic                free_q, free_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic [HALF_W-1:0]   data0_q, data1_q;

  logic                push, pop, full, empty;
  logic [CW-1:0]       count, count_next;
  logic [2*HALF_W-1:0] rdata;

  assign push       = i_drive && !full;
  assign pop        = (state_q == ST_POP) && !empty;
  assign count_next = count + CW'(push) - CW'(pop);

  c_sync_fifo #(
    .WIDTH (2*HALF_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_data_64),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Drive is decided one cycle ahead, so the head word is already in place
  // when the pulse appears.
  always_comb begin
    state_d = state_q;
    drive_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_next != '0) begin
          state_d = ST_WAIT_BOTH;
          drive_d = 1'b1;
        end
      end
      ST_WAIT_BOTH: begin
        if (i_freeNext0 && i_freeNext1) begin
          state_d = ST_POP;
        end else if (i_freeNext0) begin
          state_d = ST_WAIT1;
        end else if (i_freeNext1) begin
          state_d = ST_WAIT0;
        end
      end
      ST_WAIT0: if (i_freeNext0) state_d = ST_POP;
      ST_WAIT1: if (i_freeNext1) state_d = ST_POP;
      ST_POP: begin
        if (count_next != '0) begin
          state_d = ST_WAIT_BOTH;
          drive_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A push that fills the FIFO withholds upstream credit until the next pop.
  always_comb begin
    free_d = (push && (count_next < CW'(DEPTH))) || (pop && pend_q);
    pend_d = pend_q ? !pop : (push && (count_next == CW'(DEPTH)));
    ovf_d  = ovf_q || (i_drive && full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      drive_q <= 1'b0;
      free_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      free_q  <= free_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      if (drive_q) begin
        data0_q <= rdata[2*HALF_W-1:HALF_W];
        data1_q <= rdata[HALF_W-1:0];
      end
    end
  end

  assign o_drive0   = drive_q;
  assign o_drive1   = drive_q;
  assign o_free     = free_q;
  assign o_overflow = ovf_q;
  assign o_data0_32 = drive_q ? rdata[2*HALF_W-1:HALF_W] : data0_q;
  assign o_data1_32 = drive_q ? rdata[HALF_W-1:0]        : data1_q;

endmodule
`default_nettype wire

// File: tb/tb_c_split2_32b.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_split2_32b
// Brief    : Scoreboard bench for c_split2_32b: directed handshake scenarios
//            followed by credit-respecting random traffic.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_c_split2_32b;

  localparam int HALF_W = 32;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_drive = 1'b0;
  logic [63:0] i_data_64 = '0;
  logic        o_free, o_drive0, o_drive1, o_overflow;
  logic [31:0] o_data0_32, o_data1_32;
  logic        i_freeNext0, i_freeNext1;
  logic        auto_f0 = 1'b0, auto_f1 = 1'b0, dir_f0 = 1'b0, dir_f1 = 1'b0;
  bit          auto_en = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last0 = '0, last1 = '0;

  assign i_freeNext0 = auto_f0 | dir_f0;
  assign i_freeNext1 = auto_f1 | dir_f1;

  always #5 clk = ~clk;

  c_split2_32b #(.HALF_W(HALF_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_drive     (i_drive),
    .i_data_64   (i_data_64),
    .o_free      (o_free),
    .o_drive0    (o_drive0),
    .o_drive1    (o_drive1),
    .o_data0_32  (o_data0_32),
    .o_data1_32  (o_data1_32),
    .i_freeNext0 (i_freeNext0),
    .i_freeNext1 (i_freeNext1),
    .o_overflow  (o_overflow)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Upstream pushes one word; accepted words become expected branch output.
  task automatic drive_word(input logic [63:0] w, input bit accepted);
    i_drive   = 1'b1;
    i_data_64 = w;
    if (accepted) exp_q.push_back(w);
    tick();
    i_drive = 1'b0;
  endtask

  // Frees the outstanding word in the given order; a second word is queued
  // with credit withheld, so its drive and the released credit appear together.
  task automatic retire_check(input int order, input logic [63:0] nxt);
    case (order)
      0: begin dir_f0 = 1'b1; tick(); dir_f0 = 1'b0; dir_f1 = 1'b1; tick(); dir_f1 = 1'b0; end
      1: begin dir_f1 = 1'b1; tick(); dir_f1 = 1'b0; dir_f0 = 1'b1; tick(); dir_f0 = 1'b0; end
      default: begin dir_f0 = 1'b1; dir_f1 = 1'b1; tick(); dir_f0 = 1'b0; dir_f1 = 1'b0; end
    endcase
    chk("pop_cycle_free", {63'd0, o_free}, 64'd0);
    chk("pop_cycle_drive", {63'd0, o_drive0}, 64'd0);
    tick();
    chk("release_free", {63'd0, o_free}, 64'd1);
    chk("next_drive", {63'd0, o_drive0}, 64'd1);
    chk("next_data0", {32'd0, o_data0_32}, {32'd0, nxt[63:32]});
  endtask

  // Monitor: scoreboard pop on every drive, hold check otherwise, and the
  // randomized branch consumers used in the random phase.
  initial begin : monitor
    int c0, c1;
    logic [63:0] w;
    c0 = 0;
    c1 = 0;
    forever begin
      @(negedge clk);
      auto_f0 = 1'b0;
      auto_f1 = 1'b0;
      if (!rst) begin
        last0 = '0; last1 = '0; c0 = 0; c1 = 0;
      end else begin
        if (c0 > 0) begin c0--; if (c0 == 0) auto_f0 = 1'b1; end
        if (c1 > 0) begin c1--; if (c1 == 0) auto_f1 = 1'b1; end
        n_cmp++;
        if (o_drive0 !== o_drive1) begin
          n_bad++;
          $display("FAIL drive_pair: drive0=%b drive1=%b required equal", o_drive0, o_drive1);
        end
        if (o_drive0 === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_drive: data 0x%0h with no word expected", {o_data0_32, o_data1_32});
          end else begin
            w = exp_q.pop_front();
            chk("drive_data", {o_data0_32, o_data1_32}, w);
          end
          last0 = o_data0_32;
          last1 = o_data1_32;
          if (auto_en) begin
            c0 = int'($urandom_range(1, 4));
            c1 = int'($urandom_range(1, 4));
          end
        end else begin
          chk("data_hold", {o_data0_32, o_data1_32}, {last0, last1});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] w;
    bit credit, abort;
    int guard;

    // Reset values
    tick(); tick();
    chk("rst_free", {63'd0, o_free}, 64'd0);
    chk("rst_drive0", {63'd0, o_drive0}, 64'd0);
    chk("rst_drive1", {63'd0, o_drive1}, 64'd0);
    chk("rst_data0", {32'd0, o_data0_32}, 64'd0);
    chk("rst_data1", {32'd0, o_data1_32}, 64'd0);
    chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
    rst = 1'b1;
    tick();

    // Single word into an empty block
    drive_word(64'hAAAA_BBBB_1111_2222, 1'b1);
    chk("t1_drive0", {63'd0, o_drive0}, 64'd1);
    chk("t1_free", {63'd0, o_free}, 64'd1);
    chk("t1_data0", {32'd0, o_data0_32}, 64'hAAAABBBB);
    chk("t1_data1", {32'd0, o_data1_32}, 64'h11112222);
    tick();
    chk("t1_free_pulse", {63'd0, o_free}, 64'd0);
    dir_f0 = 1'b1; tick(); dir_f0 = 1'b0;
    tick();
    dir_f1 = 1'b1; tick(); dir_f1 = 1'b0;
    chk("t1_pop_nodrive", {63'd0, o_drive0}, 64'd0);
    tick();

    // Block is idle and empty again: next word issues immediately
    drive_word(64'h0123_4567_89AB_CDEF, 1'b1);
    chk("idle_push_drive", {63'd0, o_drive0}, 64'd1);
    chk("idle_push_free", {63'd0, o_free}, 64'd1);
    w = 64'hC0C0_0001_D0D0_0002;
    drive_word(w, 1'b1);
    chk("fill_no_free", {63'd0, o_free}, 64'd0);
    retire_check(0, w);
    w = 64'h1357_9BDF_2468_ACE0;
    drive_word(w, 1'b1);
    chk("fill2_no_free", {63'd0, o_free}, 64'd0);
    retire_check(1, w);
    w = 64'hFEED_FACE_CAFE_BEEF;
    drive_word(w, 1'b1);
    retire_check(2, w);

    // Overflow: a word arriving while full is dropped
    w = 64'h5555_6666_7777_8888;
    drive_word(w, 1'b1);
    chk("ovf_pre", {63'd0, o_overflow}, 64'd0);
    drive_word(64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
    chk("ovf_set", {63'd0, o_overflow}, 64'd1);
    tick();
    chk("ovf_sticky", {63'd0, o_overflow}, 64'd1);
    retire_check(2, w);
    chk("ovf_sticky2", {63'd0, o_overflow}, 64'd1);

    // Reset while waiting on branch 0 with the FIFO full
    drive_word(64'h9999_AAAA_BBBB_CCCC, 1'b1);
    dir_f1 = 1'b1; tick(); dir_f1 = 1'b0;
    rst = 1'b0;
    tick();
    chk("mrst_free", {63'd0, o_free}, 64'd0);
    chk("mrst_drive", {63'd0, o_drive0}, 64'd0);
    chk("mrst_data0", {32'd0, o_data0_32}, 64'd0);
    chk("mrst_data1", {32'd0, o_data1_32}, 64'd0);
    chk("mrst_ovf", {63'd0, o_overflow}, 64'd0);
    exp_q.delete();
    rst = 1'b1;
    drive_word(64'h1111_0000_2222_0000, 1'b1);
    chk("post_rst_drive", {63'd0, o_drive0}, 64'd1);
    chk("post_rst_free", {63'd0, o_free}, 64'd1);
    dir_f0 = 1'b1; dir_f1 = 1'b1; tick(); dir_f0 = 1'b0; dir_f1 = 1'b0;
    tick();

    // Spurious frees in IDLE are ignored
    dir_f0 = 1'b1; dir_f1 = 1'b1; tick(); dir_f0 = 1'b0; dir_f1 = 1'b0;
    dir_f1 = 1'b1; tick(); dir_f1 = 1'b0;
    tick();
    drive_word(64'h4242_4242_2424_2424, 1'b1);
    chk("spur_drive", {63'd0, o_drive0}, 64'd1);
    chk("spur_free", {63'd0, o_free}, 64'd1);

    // Repeated free on an already-freed branch does not retire the word
    w = 64'h7777_0000_0000_7777;
    drive_word(w, 1'b1);
    dir_f0 = 1'b1; tick(); dir_f0 = 1'b0;
    dir_f0 = 1'b1; tick(); dir_f0 = 1'b0;
    tick(); tick();
    chk("repeat_no_drive", {63'd0, o_drive0}, 64'd0);
    chk("repeat_no_free", {63'd0, o_free}, 64'd0);
    dir_f1 = 1'b1; tick(); dir_f1 = 1'b0;
    chk("repeat_pop_free", {63'd0, o_free}, 64'd0);
    tick();
    chk("repeat_release", {63'd0, o_free}, 64'd1);
    chk("repeat_next", {63'd0, o_drive0}, 64'd1);

    // Random traffic with randomized branch free latency
    rst = 1'b0;
    tick(); tick();
    exp_q.delete();
    rst = 1'b1;
    auto_en = 1'b1;
    tick();
    credit = 1'b1;
    abort  = 1'b0;
    for (int k = 0; k < 150; k++) begin
      guard = 0;
      while (!credit && !abort) begin
        if (o_free === 1'b1) begin
          credit = 1'b1;
        end else begin
          tick();
          guard++;
          if (guard > 60) begin
            abort = 1'b1;
            n_cmp++;
            n_bad++;
            $display("FAIL credit_timeout: no o_free within %0d cycles, required a pulse", guard);
          end
        end
      end
      if (abort) break;
      repeat ($urandom_range(0, 2)) tick();
      w = {$urandom, $urandom};
      drive_word(w, 1'b1);
      credit = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("final_ovf", {63'd0, o_overflow}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
